// File: rtl/seq_detector_param.sv
// Parametrised serial token pattern detector with overlap control and illegal-token flagging.
// Optional saturating match counter is built only when SEQ_DET_MATCH_CNT_EN is defined.
module seq_detector_param #(
  parameter int unsigned  PAT_LEN = 4,
  parameter logic [15:0]  PATTERN = 16'b1011,
  parameter int unsigned  OVERLAP = 1,
  parameter int unsigned  CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ONE,
  input  logic             ZERO,
  output logic             OUT,
  output logic             ERR,
  output logic [CNT_W-1:0] MATCH_CNT
);

  localparam int unsigned FW = $clog2(PAT_LEN + 1);
  localparam logic [FW-1:0] FULL = FW'(PAT_LEN);
  localparam logic [PAT_LEN-1:0] PAT = PATTERN[PAT_LEN-1:0];

  typedef enum logic {HUNT, ARMED} state_t;

  state_t             state;
  logic [PAT_LEN-1:0] hist;
  logic [FW-1:0]      fill;

  logic               tok_one;
  logic               valid;
  logic               illegal;
  logic [PAT_LEN:0]   shifted;
  logic [PAT_LEN-1:0] hist_nxt;
  logic [FW-1:0]      fill_nxt;
  logic               match;

  // Shift through a one-bit-wider vector so PAT_LEN=1 needs no special case.
  always_comb begin
    tok_one  = ONE & ~ZERO;
    valid    = ONE ^ ZERO;
    illegal  = ONE & ZERO;
    shifted  = {hist, tok_one};
    hist_nxt = shifted[PAT_LEN-1:0];
    fill_nxt = (state == ARMED) ? FULL : fill + FW'(1);
    match    = valid && (fill_nxt == FULL) && (hist_nxt == PAT);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= HUNT;
      hist  <= '0;
      fill  <= '0;
      OUT   <= 1'b0;
      ERR   <= 1'b0;
    end else begin
      OUT <= 1'b0;
      ERR <= 1'b0;
      if (illegal) begin
        state <= HUNT;
        hist  <= '0;
        fill  <= '0;
        ERR   <= 1'b1;
      end else if (valid) begin
        hist <= hist_nxt;
        if (match) begin
          OUT <= 1'b1;
          if (OVERLAP != 0) begin
            fill  <= fill_nxt;
            state <= ARMED;
          end else begin
            fill  <= '0;
            state <= HUNT;
          end
        end else begin
          fill  <= fill_nxt;
          state <= (fill_nxt == FULL) ? ARMED : HUNT;
        end
      end
    end
  end

`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt;

  // Advances on the same edge that registers OUT, so count and pulse line up.
  always_ff @(posedge CLK) begin
    if (RESET)
      cnt <= '0;
    else if (match && (cnt != '1))
      cnt <= cnt + CNT_W'(1);
  end

  assign MATCH_CNT = cnt;
`else
  assign MATCH_CNT = '0;
`endif

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param: default, non-overlap, narrow-counter and PAT_LEN=1 instances.
// Honours SEQ_DET_MATCH_CNT_EN when forming expected counter values.
module tb_seq_detector_param;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       one = 1'b0;
  logic       zero = 1'b0;

  logic       out0, err0, out1, err1, out2, err2, out3, err3;
  logic [7:0] cnt0, cnt1, cnt3;
  logic [1:0] cnt2;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  seq_detector_param u0 (
    .CLK(clk), .RESET(rst), .ONE(one), .ZERO(zero),
    .OUT(out0), .ERR(err0), .MATCH_CNT(cnt0));

  seq_detector_param #(.OVERLAP(0)) u1 (
    .CLK(clk), .RESET(rst), .ONE(one), .ZERO(zero),
    .OUT(out1), .ERR(err1), .MATCH_CNT(cnt1));

  seq_detector_param #(.CNT_W(2)) u2 (
    .CLK(clk), .RESET(rst), .ONE(one), .ZERO(zero),
    .OUT(out2), .ERR(err2), .MATCH_CNT(cnt2));

  seq_detector_param #(.PAT_LEN(1), .PATTERN(16'b1)) u3 (
    .CLK(clk), .RESET(rst), .ONE(one), .ZERO(zero),
    .OUT(out3), .ERR(err3), .MATCH_CNT(cnt3));

  function automatic logic [31:0] ec(input int n);
`ifdef SEQ_DET_MATCH_CNT_EN
    return 32'(n);
`else
    return 32'(n - n);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs sampled 1 time unit after the rising edge.
  task automatic step(input logic o, input logic z, input logic r,
                      input logic e0, input logic e1, input logic e3, input logic ee,
                      input string tag);
    @(negedge clk);
    one = o; zero = z; rst = r;
    @(posedge clk);
    #1;
    chk({tag, ".out0"}, 32'(out0), 32'(e0));
    chk({tag, ".out1"}, 32'(out1), 32'(e1));
    chk({tag, ".out2"}, 32'(out2), 32'(e0));
    chk({tag, ".out3"}, 32'(out3), 32'(e3));
    chk({tag, ".err0"}, 32'(err0), 32'(ee));
    chk({tag, ".err3"}, 32'(err3), 32'(ee));
  endtask

  task automatic do_reset(input string tag);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, tag);
    chk({tag, ".cnt0"}, 32'(cnt0), 32'd0);
    chk({tag, ".cnt1"}, 32'(cnt1), 32'd0);
    chk({tag, ".cnt2"}, 32'(cnt2), 32'd0);
    chk({tag, ".cnt3"}, 32'(cnt3), 32'd0);
  endtask

  initial begin
    logic [15:0] seq_e;
    logic        t;
    seq_e = 16'b1011011011011011;

    // Reset state, with a token presented to show reset priority
    @(negedge clk);
    one = 1'b1;
    do_reset("rst0");

    // Tokens 1,0,1,1,0,1,1
    step(1, 0, 0, 0, 0, 1, 0, "a1");
    step(0, 1, 0, 0, 0, 0, 0, "a2");
    step(1, 0, 0, 0, 0, 1, 0, "a3");
    step(1, 0, 0, 1, 1, 1, 0, "a4");
    step(0, 1, 0, 0, 0, 0, 0, "a5");
    step(1, 0, 0, 0, 0, 1, 0, "a6");
    step(1, 0, 0, 1, 0, 1, 0, "a7");
    step(0, 0, 0, 0, 0, 0, 0, "a_idle");
    chk("a.cnt0", 32'(cnt0), ec(2));
    chk("a.cnt1", 32'(cnt1), ec(1));
    chk("a.cnt2", 32'(cnt2), ec(2));
    chk("a.cnt3", 32'(cnt3), ec(5));

    // Idle gaps inside a partial match
    do_reset("rst1");
    step(1, 0, 0, 0, 0, 1, 0, "b1");
    step(0, 1, 0, 0, 0, 0, 0, "b2");
    step(0, 0, 0, 0, 0, 0, 0, "b3");
    step(0, 0, 0, 0, 0, 0, 0, "b4");
    step(1, 0, 0, 0, 0, 1, 0, "b5");
    step(1, 0, 0, 1, 1, 1, 0, "b6");

    // Illegal token discards history
    do_reset("rst2");
    step(1, 0, 0, 0, 0, 1, 0, "c1");
    step(0, 1, 0, 0, 0, 0, 0, "c2");
    step(1, 0, 0, 0, 0, 1, 0, "c3");
    step(1, 1, 0, 0, 0, 0, 1, "c4");
    step(1, 1, 0, 0, 0, 0, 1, "c5");
    step(1, 0, 0, 0, 0, 1, 0, "c6");
    chk("c.err1", 32'(err1), 32'd0);
    chk("c.cnt3", 32'(cnt3), ec(3));

    // Reset mid-pattern
    do_reset("rst3");
    step(1, 0, 0, 0, 0, 1, 0, "d1");
    step(0, 1, 0, 0, 0, 0, 0, "d2");
    step(1, 0, 0, 0, 0, 1, 0, "d3");
    step(1, 0, 1, 0, 0, 0, 0, "d_rst");
    chk("d_rst.cnt3", 32'(cnt3), 32'd0);
    step(1, 0, 0, 0, 0, 1, 0, "d4");

    // Sixteen back-to-back tokens: saturation of the 2-bit counter, non-overlap restarts
    do_reset("rst4");
    for (int i = 1; i <= 16; i++) begin
      t = seq_e[16 - i];
      step(t, ~t, 1'b0,
           (i >= 4) && (i % 3 == 1),
           (i == 4) || (i == 10) || (i == 16),
           t, 1'b0, $sformatf("e%0d", i));
    end
    chk("e.cnt0", 32'(cnt0), ec(5));
    chk("e.cnt1", 32'(cnt1), ec(3));
    chk("e.cnt2", 32'(cnt2), ec(3));
    chk("e.cnt3", 32'(cnt3), ec(11));

    // An illegal token leaves the counter alone
    step(1, 1, 0, 0, 0, 0, 1, "f_ill");
    chk("f.cnt0", 32'(cnt0), ec(5));
    chk("f.cnt2", 32'(cnt2), ec(3));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, observed running expected done");
    $fatal(1);
  end

endmodule
